// File: rtl/currency_accum_mc_pkg.sv
// Shared widths, operation select and priority helper for the multi-channel
// currency accumulator.
package currency_pkg;

    localparam int CURRENCY_WIDTH_D = 7;
    localparam int TOTAL_WIDTH_D    = 10;
    localparam int MAX_CREDIT_D     = 1000;
    localparam int MAX_CH           = 8;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_DEDUCT,
        OP_REFUND
    } op_e;

    // Isolates the lowest set bit: two's-complement trick, x & -x.
    function automatic logic [MAX_CH-1:0] onehot_lowest(input logic [MAX_CH-1:0] vec);
        onehot_lowest = vec & (~vec + 8'd1);
    endfunction

endpackage

// File: rtl/currency_accum_mc_if.sv
// Acceptor / vend-controller signal bundle of the currency accumulator.
interface currency_accum_mc_if
    import currency_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CURRENCY_WIDTH = CURRENCY_WIDTH_D,
    parameter int TOTAL_WIDTH    = TOTAL_WIDTH_D
);
    logic                             enable;
    logic [NUM_CH-1:0]                currency_valid;
    logic [NUM_CH*CURRENCY_WIDTH-1:0] currency_value;
    logic                             deduct_req;
    logic [TOTAL_WIDTH-1:0]           deduct_amount;
    logic                             refund_req;
    logic [TOTAL_WIDTH-1:0]           total_currency;
    logic                             currency_avail;
    logic [NUM_CH-1:0]                accepted_ch;
    logic                             currency_reject;
    logic                             deduct_ack;
    logic                             deduct_nack;
    logic                             refund_valid;
    logic [TOTAL_WIDTH-1:0]           refund_value;
    logic [NUM_CH-1:0]                pending;

    modport master (
        output enable, currency_valid, currency_value,
        output deduct_req, deduct_amount, refund_req,
        input  total_currency, currency_avail, accepted_ch, currency_reject,
        input  deduct_ack, deduct_nack, refund_valid, refund_value, pending
    );

    modport slave (
        input  enable, currency_valid, currency_value,
        input  deduct_req, deduct_amount, refund_req,
        output total_currency, currency_avail, accepted_ch, currency_reject,
        output deduct_ack, deduct_nack, refund_valid, refund_value, pending
    );
endinterface

// File: rtl/currency_accum_mc_sync_edge.sv
// One channel: multi-flop synchroniser for an asynchronous strobe, then a
// history flop producing a single-cycle rise indication.
module currency_sync_edge
    import currency_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic async_in,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/currency_accum_mc.sv
// Multi-channel currency accumulator: per-channel edge detection, fixed
// priority servicing, saturation-checked credit, deduct and refund.
module currency_accum_mc
    import currency_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CURRENCY_WIDTH = CURRENCY_WIDTH_D,
    parameter int TOTAL_WIDTH    = TOTAL_WIDTH_D,
    parameter int MAX_CREDIT     = MAX_CREDIT_D,
    parameter int SYNC_STAGES    = 2
) (
    input logic              clk,
    input logic              rstn,
    currency_accum_mc_if.slave bus
);
    localparam int CW     = CURRENCY_WIDTH;
    localparam int TW     = TOTAL_WIDTH;
    localparam int SW     = TOTAL_WIDTH + 1;
    localparam int WARM_W = $clog2(SYNC_STAGES + 2);

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] rise_m;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [MAX_CH-1:0] req_wide;
    logic [MAX_CH-1:0] grant_wide;
    logic [CW-1:0]     add_value;
    logic [SW-1:0]     sum;
    logic              over;
    op_e               op;
    logic              warm_done;
    logic [WARM_W-1:0] warm_reg;

    logic [TW-1:0]     total_reg,   total_next;
    logic              avail_reg,   avail_next;
    logic              reject_reg,  reject_next;
    logic [NUM_CH-1:0] acc_reg,     acc_next;
    logic              dack_reg,    dack_next;
    logic              dnack_reg,   dnack_next;
    logic              rv_reg,      rv_next;
    logic [TW-1:0]     rval_reg,    rval_next;
    logic [NUM_CH-1:0] pending_reg, pending_next;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            currency_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk      (clk),
                .rstn     (rstn),
                .async_in (bus.currency_valid[gi]),
                .rise     (rise[gi])
            );
        end
    endgenerate

    // Edges are ignored until the synchroniser and history have refilled
    // after reset, so a strobe already high at release is never counted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            warm_reg <= '0;
        end else if (!warm_done) begin
            warm_reg <= warm_reg + 1'b1;
        end
    end

    assign warm_done = (warm_reg == WARM_W'(SYNC_STAGES + 1));
    assign rise_m    = warm_done ? rise : '0;
    assign req       = pending_reg | rise_m;

    always_comb begin
        op = OP_NONE;
        if (bus.refund_req) begin
            op = OP_REFUND;
        end else if (bus.deduct_req) begin
            op = OP_DEDUCT;
        end else if (|req) begin
            op = OP_ADD;
        end
    end

    always_comb begin
        req_wide             = '0;
        req_wide[NUM_CH-1:0] = req;
    end

    assign grant_wide = onehot_lowest(req_wide);
    assign grant      = (op == OP_ADD) ? grant_wide[NUM_CH-1:0] : '0;

    always_comb begin
        add_value = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                add_value = bus.currency_value[i*CW +: CW];
            end
        end
    end

    assign sum  = {1'b0, total_reg} + SW'(add_value);
    assign over = (sum > SW'(MAX_CREDIT));

    always_comb begin
        total_next   = total_reg;
        avail_next   = 1'b0;
        reject_next  = 1'b0;
        acc_next     = '0;
        dack_next    = 1'b0;
        dnack_next   = 1'b0;
        rv_next      = 1'b0;
        rval_next    = '0;
        pending_next = req & ~grant;
        case (op)
            OP_REFUND: begin
                rv_next    = 1'b1;
                rval_next  = total_reg;
                total_next = '0;
            end
            OP_DEDUCT: begin
                if (bus.deduct_amount <= total_reg) begin
                    total_next = total_reg - bus.deduct_amount;
                    dack_next  = 1'b1;
                end else begin
                    dnack_next = 1'b1;
                end
            end
            OP_ADD: begin
                acc_next = grant;
                if (!bus.enable || over) begin
                    reject_next = 1'b1;
                end else begin
                    total_next = sum[TW-1:0];
                    avail_next = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total_reg   <= '0;
            avail_reg   <= 1'b0;
            reject_reg  <= 1'b0;
            acc_reg     <= '0;
            dack_reg    <= 1'b0;
            dnack_reg   <= 1'b0;
            rv_reg      <= 1'b0;
            rval_reg    <= '0;
            pending_reg <= '0;
        end else begin
            total_reg   <= total_next;
            avail_reg   <= avail_next;
            reject_reg  <= reject_next;
            acc_reg     <= acc_next;
            dack_reg    <= dack_next;
            dnack_reg   <= dnack_next;
            rv_reg      <= rv_next;
            rval_reg    <= rval_next;
            pending_reg <= pending_next;
        end
    end

    assign bus.total_currency  = total_reg;
    assign bus.currency_avail  = avail_reg;
    assign bus.currency_reject = reject_reg;
    assign bus.accepted_ch     = acc_reg;
    assign bus.deduct_ack      = dack_reg;
    assign bus.deduct_nack     = dnack_reg;
    assign bus.refund_valid    = rv_reg;
    assign bus.refund_value    = rval_reg;
    assign bus.pending         = pending_reg;

endmodule

// File: tb/tb_currency_accum_mc.sv
// Randomised plus directed bench for currency_accum_mc against an
// event-level model of credit, pending set and pulse outputs.
module tb_currency_accum_mc;
    import currency_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CW     = 7;
    localparam int TW     = 10;
    localparam int MAXC   = 1000;
    localparam int S      = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    currency_accum_mc_if #(.NUM_CH(NUM_CH), .CURRENCY_WIDTH(CW), .TOTAL_WIDTH(TW)) bus ();

    currency_accum_mc #(
        .NUM_CH(NUM_CH), .CURRENCY_WIDTH(CW), .TOTAL_WIDTH(TW),
        .MAX_CREDIT(MAXC), .SYNC_STAGES(S)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: credit, pending set, pulse outputs, and for each channel
    // the strobe samples of the last S+1 edges (newest at index 0). Samples
    // from before reset count as high, so a pre-existing strobe must drop first.
    int              m_total;
    bit [NUM_CH-1:0] m_pend, m_acc;
    bit              m_avail, m_rej, m_dack, m_dnack, m_rv;
    int              m_rval;
    bit              h [NUM_CH][S+1];
    bit [NUM_CH-1:0] mr, mreq;
    int              mg, mv;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_total = 0; m_pend = '0; m_acc = '0; m_avail = 0; m_rej = 0;
            m_dack = 0; m_dnack = 0; m_rv = 0; m_rval = 0;
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k <= S; k++) h[c][k] = 1'b1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                mr[c] = h[c][S-1] && !h[c][S];
                for (int k = S; k > 0; k--) h[c][k] = h[c][k-1];
                h[c][0] = bus.currency_valid[c];
            end
            m_acc = '0; m_avail = 0; m_rej = 0; m_dack = 0; m_dnack = 0;
            m_rv = 0; m_rval = 0;
            mreq = m_pend | mr;
            m_pend = mreq;
            if (bus.refund_req) begin
                m_rv = 1; m_rval = m_total; m_total = 0;
            end else if (bus.deduct_req) begin
                if (int'(bus.deduct_amount) <= m_total) begin
                    m_total -= int'(bus.deduct_amount); m_dack = 1;
                end else begin
                    m_dnack = 1;
                end
            end else if (mreq != 0) begin
                mg = 0;
                while (!mreq[mg]) mg++;
                mv = int'(bus.currency_value[mg*CW +: CW]);
                m_acc = NUM_CH'(1) << mg;
                m_pend = mreq & ~m_acc;
                if (!bus.enable || (m_total + mv > MAXC)) m_rej = 1;
                else begin m_total += mv; m_avail = 1; end
            end
        end
    end

    always @(negedge clk) begin
        chk("total",   int'(bus.total_currency),  m_total);
        chk("avail",   int'(bus.currency_avail),  int'(m_avail));
        chk("reject",  int'(bus.currency_reject), int'(m_rej));
        chk("acc_ch",  int'(bus.accepted_ch),     int'(m_acc));
        chk("dack",    int'(bus.deduct_ack),      int'(m_dack));
        chk("dnack",   int'(bus.deduct_nack),     int'(m_dnack));
        chk("rv",      int'(bus.refund_valid),    int'(m_rv));
        chk("rval",    int'(bus.refund_value),    m_rval);
        chk("pending", int'(bus.pending),         int'(m_pend));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_val(input int c, input int v);
        bus.currency_value[c*CW +: CW] = CW'(v);
    endtask

    task automatic do_refund(input int exp_val);
        bus.refund_req = 1'b1;
        step(1);
        bus.refund_req = 1'b0;
        chk("refund_valid", int'(bus.refund_valid), 1);
        chk("refund_value", int'(bus.refund_value), exp_val);
        chk("refund_total", int'(bus.total_currency), 0);
        chk("model_refund", m_rval, exp_val);
        $display("refund -> value %0d", bus.refund_value);
    endtask

    task automatic do_deduct(input int amt, input int exp_ack, input int exp_total);
        bus.deduct_amount = TW'(amt);
        bus.deduct_req    = 1'b1;
        step(1);
        bus.deduct_req = 1'b0;
        chk("deduct_ack",   int'(bus.deduct_ack),  exp_ack);
        chk("deduct_nack",  int'(bus.deduct_nack), 1 - exp_ack);
        chk("deduct_total", int'(bus.total_currency), exp_total);
        $display("deduct %0d -> ack %0b nack %0b total %0d", amt, bus.deduct_ack, bus.deduct_nack, bus.total_currency);
    endtask

    bit [NUM_CH-1:0] busy;
    int              hold [NUM_CH];

    initial begin
        bus.enable = 1'b1; bus.currency_valid = '0; bus.currency_value = '0;
        bus.deduct_req = 1'b0; bus.deduct_amount = '0; bus.refund_req = 1'b0;
        step(3);
        chk("rst_total", int'(bus.total_currency), 0);
        chk("rst_pending", int'(bus.pending), 0);
        rstn = 1'b1;
        step(6);

        // single insert, strobe held for many cycles
        set_val(1, 25); bus.currency_valid[1] = 1'b1;
        step(3);
        chk("single_avail", int'(bus.currency_avail), 1);
        chk("single_acc",   int'(bus.accepted_ch), 4'b0010);
        chk("single_total", int'(bus.total_currency), 25);
        chk("model_single", m_total, 25);
        $display("insert ch1 25 -> total %0d", bus.total_currency);
        step(8); bus.currency_valid[1] = 1'b0; step(2);
        chk("single_once", int'(bus.total_currency), 25);
        do_refund(25);
        step(1);

        // simultaneous ch0 and ch2
        set_val(0, 10); set_val(2, 50);
        bus.currency_valid[0] = 1'b1; bus.currency_valid[2] = 1'b1;
        step(3);
        chk("sim_acc0",  int'(bus.accepted_ch), 4'b0001);
        chk("sim_tot0",  int'(bus.total_currency), 10);
        chk("sim_pend",  int'(bus.pending), 4'b0100);
        step(1);
        chk("sim_acc2",  int'(bus.accepted_ch), 4'b0100);
        chk("sim_tot2",  int'(bus.total_currency), 60);
        chk("sim_pend0", int'(bus.pending), 0);
        $display("insert ch0 10 + ch2 50 -> total %0d", bus.total_currency);
        bus.currency_valid[0] = 1'b0; bus.currency_valid[2] = 1'b0;
        step(2);

        do_deduct(45, 1, 15);
        do_deduct(20, 0, 15);
        do_refund(15);

        // disabled insert
        bus.enable = 1'b0; set_val(3, 5); bus.currency_valid[3] = 1'b1;
        step(3);
        chk("dis_reject", int'(bus.currency_reject), 1);
        chk("dis_acc",    int'(bus.accepted_ch), 4'b1000);
        chk("dis_total",  int'(bus.total_currency), 0);
        $display("disabled insert ch3 5 -> reject %0b", bus.currency_reject);
        bus.currency_valid[3] = 1'b0; bus.enable = 1'b1;
        step(2);

        // fill to 990 then overflow
        for (int i = 0; i < 9; i++) begin
            set_val(0, 110); bus.currency_valid[0] = 1'b1;
            step(3); bus.currency_valid[0] = 1'b0; step(1);
        end
        chk("fill_total", int'(bus.total_currency), 990);
        set_val(1, 20); bus.currency_valid[1] = 1'b1;
        step(3);
        chk("ovf_reject", int'(bus.currency_reject), 1);
        chk("ovf_acc",    int'(bus.accepted_ch), 4'b0010);
        chk("ovf_total",  int'(bus.total_currency), 990);
        $display("insert ch1 20 at 990 -> reject %0b", bus.currency_reject);
        bus.currency_valid[1] = 1'b0; step(1);
        set_val(1, 10); bus.currency_valid[1] = 1'b1;
        step(3);
        chk("max_avail", int'(bus.currency_avail), 1);
        chk("max_total", int'(bus.total_currency), 1000);
        $display("insert ch1 10 -> total %0d", bus.total_currency);
        bus.currency_valid[1] = 1'b0; step(2);
        do_refund(1000);
        step(1);

        // deduct in the grant cycle defers the add
        set_val(0, 30); bus.currency_valid[0] = 1'b1;
        step(2);
        bus.deduct_amount = '0; bus.deduct_req = 1'b1;
        step(1);
        bus.deduct_req = 1'b0;
        chk("defer_ack",   int'(bus.deduct_ack), 1);
        chk("defer_avail", int'(bus.currency_avail), 0);
        chk("defer_pend",  int'(bus.pending), 4'b0001);
        step(1);
        chk("defer_add",   int'(bus.currency_avail), 1);
        chk("defer_total", int'(bus.total_currency), 30);
        $display("deferred insert ch0 30 -> total %0d", bus.total_currency);
        bus.currency_valid[0] = 1'b0; step(1);

        // reset with pending 0011 and credit 40
        set_val(2, 10); bus.currency_valid[2] = 1'b1;
        step(3); bus.currency_valid[2] = 1'b0; step(1);
        bus.deduct_amount = '0; bus.deduct_req = 1'b1;
        set_val(0, 5); set_val(1, 7);
        bus.currency_valid[0] = 1'b1; bus.currency_valid[1] = 1'b1;
        step(4);
        chk("prerst_pend",  int'(bus.pending), 4'b0011);
        chk("prerst_total", int'(bus.total_currency), 40);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_total", int'(bus.total_currency), 0);
        chk("rst_mid_pend",  int'(bus.pending), 0);
        chk("rst_mid_ack",   int'(bus.deduct_ack), 0);
        bus.deduct_req = 1'b0;
        step(2);
        rstn = 1'b1;
        step(8);
        chk("post_rst_total", int'(bus.total_currency), 0);
        chk("post_rst_pend",  int'(bus.pending), 0);
        $display("reset with held strobes -> total %0d", bus.total_currency);
        bus.currency_valid = '0;
        step(3);

        // randomised traffic
        busy = '0;
        for (int c = 0; c < NUM_CH; c++) hold[c] = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            busy &= ~m_acc;
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.currency_valid[c]) begin
                    if (hold[c] > 0) hold[c]--;
                    else bus.currency_valid[c] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    if (!busy[c]) set_val(c, int'($urandom_range(0, 127)));
                    busy[c] = 1'b1;
                    bus.currency_valid[c] = 1'b1;
                    hold[c] = int'($urandom_range(0, 5));
                end
            end
            bus.enable        = ($urandom_range(0, 15) != 0);
            bus.refund_req    = ($urandom_range(0, 39) == 0);
            bus.deduct_req    = ($urandom_range(0, 9) == 0);
            bus.deduct_amount = TW'($urandom_range(0, 300));
            if ($urandom_range(0, 799) == 0) begin
                #2 rstn = 1'b0;
                step(1);
                rstn = 1'b1;
                busy = '0;
            end
            step(1);
        end
        bus.refund_req = 1'b0; bus.deduct_req = 1'b0; bus.currency_valid = '0;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/currency_accum_mc.md
Name: currency_accum_mc

Overview:
- Multi-channel successor to the single-input currency validator.
- Accepts asynchronous currency_valid strobes from NUM_CH independent acceptors (coin slots, note reader), synchronises each one and detects its rising edge. Arbitrates simultaneous insertions and accumulates the value into one saturation-checked credit total.
- Supports a price deduction handshake from the vend controller and a full refund. Sits between the acceptor front-ends and the vend FSM.

Parameters:
- NUM_CH, 4, number of currency input channels (1..8).
- CURRENCY_WIDTH, 7, width of each channel's value.
- TOTAL_WIDTH, 10, width of the credit total. Must be >= CURRENCY_WIDTH.
- MAX_CREDIT, 1000, largest legal total. Must be <= 2**TOTAL_WIDTH-1.
- SYNC_STAGES, 2, synchroniser depth per channel (>= 2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  synchronous; 1 = accept insertions, 0 = reject them.
- currency_valid  in  NUM_CH  asynchronous per-channel strobe. Only the rising edge is significant.
- currency_value  in  NUM_CH*CURRENCY_WIDTH  channel i occupies bits [i*CW +: CW]. Held stable from the strobe rise until that channel's avail/reject pulse.
- deduct_req  in  1  synchronous single-cycle request to subtract deduct_amount.
- deduct_amount  in  TOTAL_WIDTH  price to subtract.
- refund_req  in  1  synchronous single-cycle request to return the whole credit.
- total_currency  out  TOTAL_WIDTH  current credit.
- currency_avail  out  1  one-cycle pulse: a coin was added.
- accepted_ch  out  NUM_CH  one-hot channel of the add or reject (valid while currency_avail or currency_reject is high, else 0).
- currency_reject  out  1  one-cycle pulse: an insertion was refused (overflow or disabled).
- deduct_ack  out  1  one-cycle pulse: deduction done.
- deduct_nack  out  1  one-cycle pulse: insufficient credit, total unchanged.
- refund_valid  out  1  one-cycle pulse.
- refund_value  out  TOTAL_WIDTH  credit returned; valid with refund_valid, else 0.
- pending  out  NUM_CH  insertions detected but not yet serviced.

Behaviour:
- Reset:
  - All outputs 0.
  - All synchroniser, history and pending flops 0.
  - A strobe that is already high when reset releases is not counted until it falls and rises again.
- Per-channel edge detection:
  - currency_valid[i] passes through SYNC_STAGES flops and then one history flop.
  - rise[i] = sync_out & ~history.
- Request vector: req = pending | rise.
  - A rise on a channel that is already pending is absorbed (no double count).
- Servicing:
  - At most one channel is serviced per cycle.
  - Fixed priority: lowest index wins.
  - Non-granted requests set or hold pending. The granted bit is cleared.
- Operation priority per cycle: refund_req > deduct_req > channel service. When refund or deduct fires, the channel grant waits (pending holds).
- Add (grant g, v = value[g]):
  - If enable = 0: currency_reject = 1, accepted_ch = onehot(g), total unchanged.
  - Else if total + v > MAX_CREDIT (computed at TOTAL_WIDTH+1 bits): currency_reject = 1, total unchanged.
  - Else: total <= total + v, currency_avail = 1, accepted_ch = onehot(g).
  - v = 0 is a valid add (avail pulses, total unchanged).
- Deduct:
  - If deduct_amount <= total: total -= amount, deduct_ack = 1.
  - Else: deduct_nack = 1, total unchanged.
  - Amount 0 acks.
- Refund: refund_value <= total, refund_valid = 1, total <= 0. If total = 0, the pulse still fires with value 0.
- Latency: with E0 = first clk edge sampling a strobe high, and no contention, total/avail update at edge E0+SYNC_STAGES. Each cycle of contention delays the update by one cycle.
- Pulse outputs are registered and deassert on the following cycle unless a new event occurs.
- Reset mid-operation: pending insertions and credit are discarded, and the state is exactly as after reset.

Decomposition:
- Package currency_pkg holds:
  - default widths (CURRENCY_WIDTH_D, TOTAL_WIDTH_D, MAX_CREDIT_D);
  - a function onehot_lowest(vector) returning the lowest set bit;
  - an op_e enum {OP_NONE, OP_ADD, OP_DEDUCT, OP_REFUND} for the per-cycle operation select.
- Sub-module currency_sync_edge: one channel's SYNC_STAGES synchroniser plus history flop, outputting rise. Instantiated NUM_CH times via generate.

Test Plan:
- Single insert: ch1 value 25, SYNC_STAGES=2 -> currency_avail and accepted_ch=0010 at E0+2, total 0->25. Strobe held high 10 cycles -> counted once.
- Simultaneous: ch0=10, ch2=50 rise on the same edge -> ch0 added at E0+2 and ch2 at E0+3, with pending=0100 in between; total=60.
- Overflow: total 990, insert 20 -> currency_reject, accepted_ch set, total stays 990. Insert 10 -> total 1000.
- Deduct: total 60, deduct 45 -> ack, total 15. Deduct 20 -> nack, total 15. A deduct issued in the same cycle as a grant defers the grant by one cycle.
- Refund and disable: total 15, refund -> refund_valid with refund_value 15, total 0. With enable=0, insert 5 -> reject, total 0.
- Reset: assert rstn low with pending=0011 and total 40 -> all outputs 0. Strobes still held high after release -> no add.
